// File: rtl/tcp_pkg.sv
// Shared TCP header constants: flag bit masks, fixed header length and the
// data-offset byte for an option-less 20-byte header.
package tcp_pkg;

    localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
    localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
    localparam logic [7:0] TCP_FLAG_RST = 8'h04;
    localparam logic [7:0] TCP_FLAG_PSH = 8'h08;
    localparam logic [7:0] TCP_FLAG_ACK = 8'h10;
    localparam logic [7:0] TCP_FLAG_URG = 8'h20;
    localparam logic [7:0] TCP_FLAG_ECE = 8'h40;
    localparam logic [7:0] TCP_FLAG_CWR = 8'h80;

    localparam int         TCP_HDR_LEN     = 20;
    localparam logic [7:0] TCP_DATA_OFFSET = 8'h50;

endpackage

// File: rtl/axis_intf.sv
// Byte-wide AXI-Stream bundle used for both the payload input and segment output.
interface axis_intf;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport MASTER (output tdata, output tvalid, output tlast, input tready);
    modport SLAVE  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/tcp_tx_hdr_serializer.sv
// Prepends a 20-byte TCP header to a payload stream; checksum is left zero for
// a later stage, and payload bytes pass straight through with no added latency.
module tcp_tx_hdr_serializer
    import tcp_pkg::*;
#(
    parameter int          MAX_PAYLOAD = 1460,
    parameter logic [15:0] URG_PTR     = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [31:0] i_seq_number,
    input  logic [31:0] i_ack_number,
    input  logic [7:0]  i_flags,
    input  logic [15:0] i_window_size,
    input  logic        i_no_data,
    input  logic [15:0] i_payload_len,
    input  logic        i_hdr_valid,
    axis_intf.SLAVE     s_axis,
    axis_intf.MASTER    m_axis,
    output logic        o_packet_done,
    output logic        o_len_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

    localparam logic [15:0] MAX_LEN      = 16'(MAX_PAYLOAD);
    localparam logic [4:0]  HDR_LAST_IDX = 5'(TCP_HDR_LEN - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  hdr_idx;
    logic [15:0] pay_cnt;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] window;
    logic        no_data;
    logic [15:0] pay_len;

    logic        accept;
    logic        out_hs;
    logic        hdr_last;
    logic        pay_last;
    logic        hdr_only;
    logic [7:0]  hdr_byte;

    always_comb begin
        case (hdr_idx)
            5'd0:    hdr_byte = src_port[15:8];
            5'd1:    hdr_byte = src_port[7:0];
            5'd2:    hdr_byte = dst_port[15:8];
            5'd3:    hdr_byte = dst_port[7:0];
            5'd4:    hdr_byte = seq_num[31:24];
            5'd5:    hdr_byte = seq_num[23:16];
            5'd6:    hdr_byte = seq_num[15:8];
            5'd7:    hdr_byte = seq_num[7:0];
            5'd8:    hdr_byte = ack_num[31:24];
            5'd9:    hdr_byte = ack_num[23:16];
            5'd10:   hdr_byte = ack_num[15:8];
            5'd11:   hdr_byte = ack_num[7:0];
            5'd12:   hdr_byte = TCP_DATA_OFFSET;
            5'd13:   hdr_byte = flags;
            5'd14:   hdr_byte = window[15:8];
            5'd15:   hdr_byte = window[7:0];
            5'd18:   hdr_byte = URG_PTR[15:8];
            5'd19:   hdr_byte = URG_PTR[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Acceptance is gated by i_rst_n so a header held during reset cannot pulse o_len_err.
    always_comb begin
        state_next    = state;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 8'h00;
        m_axis.tlast  = 1'b0;
        s_axis.tready = 1'b0;
        o_packet_done = 1'b0;
        o_len_err     = 1'b0;
        accept        = 1'b0;
        out_hs        = 1'b0;
        hdr_last      = (hdr_idx == HDR_LAST_IDX);
        pay_last      = (pay_cnt == pay_len - 16'd1);
        hdr_only      = no_data || (pay_len == 16'd0);
        case (state)
            IDLE: begin
                if (i_hdr_valid && i_rst_n) begin
                    accept     = 1'b1;
                    o_len_err  = (i_payload_len > MAX_LEN);
                    state_next = HDR;
                end
            end
            HDR: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = hdr_byte;
                m_axis.tlast  = hdr_last && hdr_only;
                out_hs        = m_axis.tready;
                if (out_hs && hdr_last) begin
                    state_next = hdr_only ? DONE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tdata  = s_axis.tdata;
                m_axis.tlast  = pay_last;
                s_axis.tready = m_axis.tready;
                out_hs        = s_axis.tvalid && m_axis.tready;
                if (out_hs) begin
                    o_len_err = (s_axis.tlast != pay_last);
                    if (pay_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                o_packet_done = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Header fields are snapshotted at accept so upstream may move on mid-segment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hdr_idx  <= '0;
            pay_cnt  <= '0;
            src_port <= '0;
            dst_port <= '0;
            seq_num  <= '0;
            ack_num  <= '0;
            flags    <= '0;
            window   <= '0;
            no_data  <= 1'b0;
            pay_len  <= '0;
        end else if (accept) begin
            hdr_idx  <= '0;
            pay_cnt  <= '0;
            src_port <= i_src_port;
            dst_port <= i_dst_port;
            seq_num  <= i_seq_number;
            ack_num  <= i_ack_number;
            flags    <= i_flags;
            window   <= i_window_size;
            no_data  <= i_no_data;
            pay_len  <= (i_payload_len > MAX_LEN) ? MAX_LEN : i_payload_len;
        end else if (out_hs) begin
            if (state == HDR) begin
                hdr_idx <= hdr_idx + 5'd1;
            end else begin
                pay_cnt <= pay_cnt + 16'd1;
            end
        end
    end

endmodule
